// File: rtl/shift_reg_ctl.sv
// shift_reg_ctl: WIDTH-bit shift register with parallel load and a
// self-timed burst-shift controller (IDLE -> SHIFT -> DONE handshake).
//
// Optional build macro: SHIFT_REG_ROTATE_EN
//   defined   -> the bit shifted out re-enters at the opposite end (rotate);
//                sin is ignored.
//   undefined -> sin fills the vacated end (plain logical shift).
module shift_reg_ctl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] amount,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             dir_q,   dir_d;
  logic             sout_q,  sout_d;
  logic             fill_bit;

`ifdef SHIFT_REG_ROTATE_EN
  // Rotate: the bit leaving one end is fed back into the other end.
  logic unused_sin;
  assign unused_sin = sin;
  assign fill_bit   = dir_q ? data_q[WIDTH-1] : data_q[0];
`else
  // Logical shift: the serial input fills the vacated end.
  assign fill_bit = sin;
`endif

  // Next-state, datapath and counter update for the burst controller.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    sout_d  = sout_q;
    case (state_q)
      ST_IDLE: begin
        // Load has priority; a simultaneous start is dropped.
        if (load) begin
          data_d = d;
        end else if (start) begin
          if (amount != '0) begin
            dir_d   = dir;
            cnt_d   = amount;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        // Direction comes from the value latched at start, not the live input.
        if (dir_q) begin
          data_d = {data_q[WIDTH-2:0], fill_bit};
          sout_d = data_q[WIDTH-1];
        end else begin
          data_d = {fill_bit, data_q[WIDTH-1:1]};
          sout_d = data_q[0];
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      sout_q  <= sout_d;
    end
  end

  assign q    = data_q;
  assign sout = sout_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_reg_ctl.sv
// Testbench for shift_reg_ctl (WIDTH=8, CNT_W=4): vector table, hand-written
// corner sequences, and randomized bursts against a behavioural model.
// Honors SHIFT_REG_ROTATE_EN the same way the design does.
module tb_shift_reg_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] d;
  logic       start;
  logic       dir;
  logic [3:0] amount;
  logic       sin;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_q;
  logic       m_sout;

  typedef struct {
    logic [7:0] d;
    logic       dir;
    logic [3:0] amt;
    logic       sin;
    logic [7:0] exp_q;
    logic       exp_sout;
  } vec_t;

  vec_t vecs[6];

  shift_reg_ctl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .d      (d),
    .start  (start),
    .dir    (dir),
    .amount (amount),
    .sin    (sin),
    .q      (q),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: one single-bit shift expressed as multiply/divide by two.
  task automatic model_shift(input logic shift_left, input logic s);
    logic out_bit;
    logic in_bit;
    out_bit = shift_left ? m_q[7] : m_q[0];
`ifdef SHIFT_REG_ROTATE_EN
    in_bit = out_bit;
`else
    in_bit = s;
`endif
    if (shift_left) m_q = 8'((int'(m_q) * 2 + int'(in_bit)) % 256);
    else            m_q = 8'(int'(m_q) / 2 + int'(in_bit) * 128);
    m_sout = out_bit;
  endtask

  task automatic do_load(input logic [7:0] val);
    load = 1'b1; d = val;
    tick();
    load = 1'b0;
    chk("load_q", q, val);
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; d = '0; start = 1'b0;
    dir = 1'b0; amount = '0; sin = 1'b0;
    m_q = '0; m_sout = 1'b0;

`ifdef SHIFT_REG_ROTATE_EN
    vecs[0] = '{8'hA5, 1'b0, 4'd3,  1'b0, 8'hB4, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 4'd2,  1'b1, 8'h96, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 4'd5,  1'b0, 8'hFF, 1'b1};
    vecs[3] = '{8'h81, 1'b1, 4'd15, 1'b0, 8'hC0, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 4'd1,  1'b1, 8'h78, 1'b0};
`else
    vecs[0] = '{8'hA5, 1'b0, 4'd3,  1'b0, 8'h14, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 4'd2,  1'b1, 8'h97, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 4'd5,  1'b0, 8'h07, 1'b1};
    vecs[3] = '{8'h81, 1'b1, 4'd15, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 4'd1,  1'b1, 8'h79, 1'b0};
`endif
    vecs[5] = '{8'h5A, 1'b0, 4'd0,  1'b1, 8'h5A, 1'b0};

    // Reset state
    #3;
    chk("rst_q", q, 8'h00);
    chk("rst_sout", sout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    chk("idle_busy", busy, 1'b0);

    // Table-driven bursts
    foreach (vecs[i]) begin
      do_load(vecs[i].d);
      start = 1'b1; dir = vecs[i].dir; amount = vecs[i].amt; sin = vecs[i].sin;
      tick();
      start = 1'b0; dir = ~vecs[i].dir;
      for (int k = 0; k < int'(vecs[i].amt); k++) begin
        chk($sformatf("v%0d_busy%0d", i, k), {busy, done}, 2'b10);
`ifdef SHIFT_REG_ROTATE_EN
        sin = vecs[i].sin ^ k[0];
`endif
        tick();
      end
      chk($sformatf("v%0d_done", i), {busy, done}, 2'b01);
      chk($sformatf("v%0d_q", i), q, vecs[i].exp_q);
      if (vecs[i].amt != 0) chk($sformatf("v%0d_sout", i), sout, vecs[i].exp_sout);
      tick();
      chk($sformatf("v%0d_idle", i), {busy, done}, 2'b00);
    end

    // Load and start together: load wins, no burst
    do_load(8'h11);
    load = 1'b1; start = 1'b1; d = 8'h42; amount = 4'd4; dir = 1'b0;
    tick();
    load = 1'b0; start = 1'b0;
    chk("prio_q", q, 8'h42);
    chk("prio_bd0", {busy, done}, 2'b00);
    tick();
    chk("prio_bd1", {busy, done}, 2'b00);
    chk("prio_q1", q, 8'h42);

    // Requests during a burst and during DONE are ignored
    do_load(8'hFF);
    start = 1'b1; dir = 1'b0; amount = 4'd5; sin = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ign_busy%0d", k), {busy, done}, 2'b10);
      if (k == 2) begin load = 1'b1; d = 8'h00; start = 1'b1; dir = 1'b1; amount = 4'd3; end
      else begin load = 1'b0; start = 1'b0; end
      tick();
    end
    chk("ign_done", {busy, done}, 2'b01);
    load = 1'b1; d = 8'h00; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
`ifdef SHIFT_REG_ROTATE_EN
    chk("ign_q", q, 8'hFF);
`else
    chk("ign_q", q, 8'h07);
`endif
    chk("ign_idle", {busy, done}, 2'b00);
    tick();
    chk("ign_idle2", {busy, done}, 2'b00);

    // Randomized bursts against the model
    m_sout = sout;
    for (int r = 0; r < 40; r++) begin
      logic       ldir;
      logic [3:0] lamt;
      m_q = 8'($urandom);
      do_load(m_q);
      ldir = 1'($urandom);
      lamt = 4'($urandom_range(0, 15));
      start = 1'b1; dir = ldir; amount = lamt; sin = 1'($urandom);
      tick();
      start = 1'b0;
      for (int k = 0; k < int'(lamt); k++) begin
        chk($sformatf("r%0d_busy%0d", r, k), {busy, done}, 2'b10);
        sin = 1'($urandom); dir = 1'($urandom); amount = 4'($urandom);
        load = 1'($urandom); d = 8'($urandom); start = 1'($urandom);
        tick();
        model_shift(ldir, sin);
      end
      load = 1'b0; start = 1'b0;
      chk($sformatf("r%0d_done", r), {busy, done}, 2'b01);
      chk($sformatf("r%0d_q", r), q, m_q);
      chk($sformatf("r%0d_sout", r), sout, m_sout);
      tick();
      chk($sformatf("r%0d_idle", r), {busy, done}, 2'b00);
    end

    // Asynchronous reset mid-burst
    do_load(8'h5A);
    start = 1'b1; dir = 1'b0; amount = 4'd6; sin = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ar_busy_pre", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("ar_q", q, 8'h00);
    chk("ar_busy", busy, 1'b0);
    chk("ar_done", done, 1'b0);
    chk("ar_sout", sout, 1'b0);
    tick();
    tick();
    chk("ar_hold", {busy, done}, 2'b00);
    reset = 1'b1;
    tick();
    chk("ar_rel", {busy, done}, 2'b00);
    do_load(8'hC3);
    tick();
    chk("ar_after", {busy, done}, 2'b00);
    chk("ar_after_q", q, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
